// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches aligned 32-bit words and presents the oldest
// DEPTH bytes as the decode window, retiring bytes on consume and restarting on flush.
module prefetch_queue #(
    parameter int          DEPTH        = 16,
    parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_address,
    output logic        bus_request,
    output logic [31:0] bus_address,
    input  logic        bus_grant,
    input  logic        bus_data_valid,
    input  logic [31:0] bus_data,
    output logic [7:0]  instruction [0:DEPTH-1],
    output logic [4:0]  instruction_count,
    input  logic        consume_valid,
    input  logic [3:0]  consume_length,
    output logic        consume_error
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_ptr_q, fetch_ptr_d;
    logic [1:0]  skip_q, skip_d;
    logic [4:0]  count_q, count_d;
    logic [7:0]  win_q [0:DEPTH-1];
    logic [7:0]  win_d [0:DEPTH-1];
    logic        err_q, err_d;

    logic        consume_ok;
    logic        append;
    logic [4:0]  len;
    logic [4:0]  base;
    logic [4:0]  idx;
    logic [4:0]  pos;

    always_comb begin
        consume_ok = consume_valid && (consume_length != 4'd0)
                     && ({1'b0, consume_length} <= count_q);
        append     = (state_q == S_WAIT) && bus_data_valid;
        len        = consume_ok ? {1'b0, consume_length} : 5'd0;
        base       = count_q - len;
        idx        = '0;
        pos        = '0;

        // Shift out retired bytes; vacated slots read as zero.
        for (int i = 0; i < DEPTH; i++) begin
            idx      = 5'(i) + len;
            win_d[i] = 8'h00;
            if (idx < 5'(DEPTH))
                win_d[i] = win_q[idx[3:0]];
        end

        // Append the useful bytes of the returned word behind the surviving bytes.
        if (append) begin
            for (int j = 0; j < 4; j++) begin
                if (5'(j) >= {3'b000, skip_q}) begin
                    pos = base + 5'(j) - {3'b000, skip_q};
                    if (pos < 5'(DEPTH))
                        win_d[pos[3:0]] = bus_data[8*j +: 8];
                end
            end
        end

        count_d     = base + (append ? (5'd4 - {3'b000, skip_q}) : 5'd0);
        fetch_ptr_d = append ? (fetch_ptr_q + 32'd4) : fetch_ptr_q;
        skip_d      = append ? 2'd0 : skip_q;
        err_d       = consume_valid && !consume_ok && !flush;

        state_d = state_q;
        case (state_q)
            S_IDLE:    if (count_q <= 5'(DEPTH - 4)) state_d = S_REQ;
            S_REQ:     if (bus_grant)                state_d = S_WAIT;
            S_WAIT:    if (bus_data_valid)           state_d = S_IDLE;
            S_DISCARD: if (bus_data_valid)           state_d = S_IDLE;
            default:                                 state_d = S_IDLE;
        endcase

        // Flush wins over everything; an outstanding fetch must be drained as stale.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                win_d[i] = 8'h00;
            count_d     = 5'd0;
            fetch_ptr_d = flush_address & 32'hFFFF_FFFC;
            skip_d      = flush_address[1:0];
            if (((state_q == S_WAIT || state_q == S_DISCARD) && !bus_data_valid)
                || (state_q == S_REQ && bus_grant))
                state_d = S_DISCARD;
            else
                state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fetch_ptr_q <= RESET_VECTOR & 32'hFFFF_FFFC;
            skip_q      <= RESET_VECTOR[1:0];
            count_q     <= 5'd0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                win_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            skip_q      <= skip_d;
            count_q     <= count_d;
            err_q       <= err_d;
            for (int i = 0; i < DEPTH; i++)
                win_q[i] <= win_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            instruction[i] = win_q[i];
    end

    assign bus_request       = (state_q == S_REQ);
    assign bus_address       = fetch_ptr_q;
    assign instruction_count = count_q;
    assign consume_error     = err_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a table of fetch/consume/idle steps with
// hand-computed results, followed by flush, discard, merge and reset sequences.
module tb_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_address;
    logic        bus_request;
    logic [31:0] bus_address;
    logic        bus_grant;
    logic        bus_data_valid;
    logic [31:0] bus_data;
    logic [7:0]  instruction [0:15];
    logic [4:0]  instruction_count;
    logic        consume_valid;
    logic [3:0]  consume_length;
    logic        consume_error;
    logic [127:0] win_flat;

    int n_cmp = 0;
    int n_err = 0;

    prefetch_queue dut (
        .clock(clock), .reset(reset), .flush(flush), .flush_address(flush_address),
        .bus_request(bus_request), .bus_address(bus_address), .bus_grant(bus_grant),
        .bus_data_valid(bus_data_valid), .bus_data(bus_data), .instruction(instruction),
        .instruction_count(instruction_count), .consume_valid(consume_valid),
        .consume_length(consume_length), .consume_error(consume_error)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < 16; i++)
            win_flat[8*i +: 8] = instruction[i];
    end

    typedef struct {
        int           kind;   // 0 fetch, 1 consume, 2 idle cycles
        logic [31:0]  val;
        logic [31:0]  addr;
        int           cnt;
        logic         err;
        logic         req;
        logic [7:0]   first;
        logic [7:0]   last;
        logic         cw;
        logic [127:0] win;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus_request && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_req_seen"}, 128'(bus_request), 128'(1));
    endtask

    task automatic fetch(input logic [31:0] word, input logic [31:0] addr, input string name);
        wait_req(name);
        chk({name, "_addr"}, 128'(bus_address), 128'(addr));
        bus_grant = 1'b1;
        tick();
        bus_grant      = 1'b0;
        bus_data_valid = 1'b1;
        bus_data       = word;
        tick();
        bus_data_valid = 1'b0;
    endtask

    task automatic consume(input logic [3:0] len);
        consume_valid  = 1'b1;
        consume_length = len;
        tick();
        consume_valid  = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] a);
        flush         = 1'b1;
        flush_address = a;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{0, 32'h44332211, 32'hFFFF_FFF0,  4, 1'b0, 1'b0, 8'h11, 8'h44, 1'b0, '0};
        vecs[1]  = '{0, 32'h88776655, 32'hFFFF_FFF4,  8, 1'b0, 1'b0, 8'h11, 8'h88, 1'b0, '0};
        vecs[2]  = '{0, 32'hCCBBAA99, 32'hFFFF_FFF8, 12, 1'b0, 1'b0, 8'h11, 8'hCC, 1'b0, '0};
        vecs[3]  = '{0, 32'h00FFEEDD, 32'hFFFF_FFFC, 16, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1,
                     128'h00FFEEDD_CCBBAA99_88776655_44332211};
        vecs[4]  = '{2, 32'd3,        32'h0,         16, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, '0};
        vecs[5]  = '{1, 32'd3,        32'h0,         13, 1'b0, 1'b0, 8'h44, 8'h00, 1'b0, '0};
        vecs[6]  = '{1, 32'd1,        32'h0,         12, 1'b0, 1'b0, 8'h55, 8'h00, 1'b0, '0};
        vecs[7]  = '{0, 32'h04030201, 32'h0000_0000, 16, 1'b0, 1'b0, 8'h55, 8'h04, 1'b1,
                     128'h04030201_00FFEEDD_CCBBAA99_88776655};
        vecs[8]  = '{1, 32'd11,       32'h0,          5, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, '0};
        vecs[9]  = '{1, 32'd7,        32'h0,          5, 1'b1, 1'b1, 8'h00, 8'h04, 1'b1,
                     128'h00000000_00000000_00000004_03020100};
        vecs[10] = '{1, 32'd0,        32'h0,          5, 1'b1, 1'b1, 8'h00, 8'h04, 1'b0, '0};
        vecs[11] = '{1, 32'd5,        32'h0,          0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, '0};

        reset = 1'b1; flush = 1'b0; flush_address = '0; bus_grant = 1'b0;
        bus_data_valid = 1'b0; bus_data = '0; consume_valid = 1'b0; consume_length = '0;
        tick();
        tick();
        chk("rst_count", 128'(instruction_count), 128'(0));
        chk("rst_req",   128'(bus_request),       128'(0));
        chk("rst_err",   128'(consume_error),     128'(0));
        chk("rst_win",   win_flat,                128'(0));
        chk("rst_addr",  128'(bus_address),       128'(32'hFFFF_FFF0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                0: fetch(vecs[i].val, vecs[i].addr, $sformatf("row%0d", i));
                1: consume(vecs[i].val[3:0]);
                default: for (int k = 0; k < int'(vecs[i].val); k++) tick();
            endcase
            chk($sformatf("row%0d_count", i), 128'(instruction_count), 128'(vecs[i].cnt));
            chk($sformatf("row%0d_err", i),   128'(consume_error),     128'(vecs[i].err));
            chk($sformatf("row%0d_req", i),   128'(bus_request),       128'(vecs[i].req));
            chk($sformatf("row%0d_first", i), 128'(instruction[0]),    128'(vecs[i].first));
            if (vecs[i].cnt > 0)
                chk($sformatf("row%0d_last", i), 128'(instruction[vecs[i].cnt-1]),
                    128'(vecs[i].last));
            if (vecs[i].cw)
                chk($sformatf("row%0d_win", i), win_flat, vecs[i].win);
        end

        // Unaligned flush target: only the top byte of the first word is kept.
        do_flush(32'h0000_1003);
        chk("fl1_count", 128'(instruction_count), 128'(0));
        chk("fl1_req",   128'(bus_request),       128'(0));
        fetch(32'hDDCCBBAA, 32'h0000_1000, "fl1");
        chk("fl1_cnt_after", 128'(instruction_count), 128'(1));
        chk("fl1_win",       win_flat,                128'h0000_00DD);
        wait_req("fl1_next");
        chk("fl1_next_addr", 128'(bus_address), 128'(32'h0000_1004));

        // Flush while a fetch is outstanding: the stale word must be dropped.
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        do_flush(32'h0000_2000);
        chk("disc_count", 128'(instruction_count), 128'(0));
        tick();
        tick();
        chk("disc_req", 128'(bus_request), 128'(0));
        bus_data_valid = 1'b1;
        bus_data       = 32'hDEADBEEF;
        tick();
        bus_data_valid = 1'b0;
        chk("disc_stale_count", 128'(instruction_count), 128'(0));
        chk("disc_stale_win",   win_flat,                128'(0));
        wait_req("disc_next");
        chk("disc_next_addr", 128'(bus_address), 128'(32'h0000_2000));
        bus_data_valid = 1'b1;
        bus_data       = 32'hCAFEF00D;
        tick();
        bus_data_valid = 1'b0;
        chk("ignore_count", 128'(instruction_count), 128'(0));
        fetch(32'h13121110, 32'h0000_2000, "disc_fetch");
        chk("disc_fetch_count", 128'(instruction_count), 128'(4));
        chk("disc_fetch_b0",    128'(instruction[0]),    128'(8'h10));

        // Consume and append in the same cycle.
        fetch(32'h17161514, 32'h0000_2004, "mrg_a");
        fetch(32'h1B1A1918, 32'h0000_2008, "mrg_b");
        consume(4'd2);
        chk("mrg_pre_count", 128'(instruction_count), 128'(10));
        wait_req("mrg");
        chk("mrg_addr", 128'(bus_address), 128'(32'h0000_200C));
        bus_grant = 1'b1;
        tick();
        bus_grant      = 1'b0;
        bus_data_valid = 1'b1;
        bus_data       = 32'h1F1E1D1C;
        consume_valid  = 1'b1;
        consume_length = 4'd2;
        tick();
        bus_data_valid = 1'b0;
        consume_valid  = 1'b0;
        chk("mrg_count", 128'(instruction_count), 128'(12));
        chk("mrg_win",   win_flat, 128'h00000000_1F1E1D1C_1B1A1918_17161514);

        // Reset with a fetch in flight; the late data must not land.
        wait_req("rmt");
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        reset     = 1'b1;
        tick();
        chk("rmt_count", 128'(instruction_count), 128'(0));
        chk("rmt_req",   128'(bus_request),       128'(0));
        reset          = 1'b0;
        bus_data_valid = 1'b1;
        bus_data       = 32'hAABBCCDD;
        tick();
        bus_data_valid = 1'b0;
        chk("rmt_late_count", 128'(instruction_count), 128'(0));
        chk("rmt_late_req",   128'(bus_request),       128'(1));
        chk("rmt_late_addr",  128'(bus_address),       128'(32'hFFFF_FFF0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
